// File: rtl/memc_bist_ctrl.sv
// ============================================================================
// memc_bist_ctrl : single-port BRAM request front-end with a post-reset
// two-pattern march self-test, built in when MEMC_BIST_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memc_bist_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BIST_LAST_ADDR = 2**ADDR_WIDTH-1
) (
  input  logic                  memc_clk,
  input  logic                  memc_reset,
  input  logic                  memc_req,
  input  logic                  memc_we,
  input  logic [ADDR_WIDTH-1:0] memc_addr,
  input  logic [DATA_WIDTH-1:0] memc_wr_data,
  output logic [DATA_WIDTH-1:0] memc_rd_data,
  output logic                  memc_rd_valid,
  output logic                  memc_busy,
  output logic                  bist_done,
  output logic                  bist_error,
  output logic [ADDR_WIDTH-1:0] bist_fail_addr,
  output logic                  bram_rd_enable,
  output logic                  bram_wr_enable,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  input  logic [DATA_WIDTH-1:0] bram_rd_data
);

  if ((DATA_WIDTH < 2) || (DATA_WIDTH % 2 != 0) ||
      (BIST_LAST_ADDR > 2**ADDR_WIDTH-1)) begin : g_param_check
    $error("memc_bist_ctrl: illegal DATA_WIDTH or BIST_LAST_ADDR");
  end

`ifdef MEMC_BIST_EN
  localparam int unsigned SW = 11;
`else
  localparam int unsigned SW = 4;
`endif

  localparam logic [SW-1:0] S_IDLE      = SW'(1);
  localparam logic [SW-1:0] S_READ      = SW'(2);
  localparam logic [SW-1:0] S_READ_WAIT = SW'(4);
  localparam logic [SW-1:0] S_WRITE     = SW'(8);
`ifdef MEMC_BIST_EN
  localparam logic [SW-1:0] S_ERROR     = SW'(16);
  localparam logic [SW-1:0] S_WR1       = SW'(32);
  localparam logic [SW-1:0] S_RD1       = SW'(64);
  localparam logic [SW-1:0] S_CHK1      = SW'(128);
  localparam logic [SW-1:0] S_WR2       = SW'(256);
  localparam logic [SW-1:0] S_RD2       = SW'(512);
  localparam logic [SW-1:0] S_CHK2      = SW'(1024);
  localparam logic [SW-1:0] S_START     = S_WR1;
  localparam logic [SW-1:0] WR_MASK     = S_WR1 | S_WR2 | S_WRITE;
  localparam logic [SW-1:0] RD_MASK     = S_RD1 | S_RD2 | S_READ;
  localparam logic [DATA_WIDTH-1:0] PATT_A    = {(DATA_WIDTH/2){2'b01}};
  localparam logic [DATA_WIDTH-1:0] PATT_B    = ~PATT_A;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BIST_LAST_ADDR);
`else
  localparam logic [SW-1:0] S_START     = S_IDLE;
  localparam logic [SW-1:0] WR_MASK     = S_WRITE;
  localparam logic [SW-1:0] RD_MASK     = S_READ;
`endif

  logic [SW-1:0]         state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  bram_rd_en_q, bram_rd_en_d;
  logic                  bram_wr_en_q, bram_wr_en_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0] bram_wr_data_q, bram_wr_data_d;
  logic                  bist_done_q, bist_done_d;
  logic                  bist_error_q, bist_error_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;

  // Strobes and busy are decoded from the next state so every output is a flop
  // that lines up with the state it belongs to.
  always_comb begin
    state_d        = state_q;
    bram_addr_d    = bram_addr_q;
    bram_wr_data_d = bram_wr_data_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = 1'b0;
`ifdef MEMC_BIST_EN
    bist_done_d    = bist_done_q;
    bist_error_d   = bist_error_q;
    fail_addr_d    = fail_addr_q;
`else
    bist_done_d    = 1'b1;
    bist_error_d   = 1'b0;
    fail_addr_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (memc_req) begin
          state_d        = memc_we ? S_WRITE : S_READ;
          bram_addr_d    = memc_addr;
          bram_wr_data_d = memc_wr_data;
        end
      end
      S_READ:      state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        rd_data_d  = bram_rd_data;
        rd_valid_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_WRITE:     state_d = S_IDLE;
`ifdef MEMC_BIST_EN
      S_WR1:       state_d = S_RD1;
      S_RD1:       state_d = S_CHK1;
      S_CHK1: begin
        if (bram_rd_data != PATT_A) begin
          state_d      = S_ERROR;
          bist_done_d  = 1'b1;
          bist_error_d = 1'b1;
          fail_addr_d  = bram_addr_q;
        end else begin
          state_d        = S_WR2;
          bram_wr_data_d = PATT_B;
        end
      end
      S_WR2:       state_d = S_RD2;
      S_RD2:       state_d = S_CHK2;
      S_CHK2: begin
        if (bram_rd_data != PATT_B) begin
          state_d      = S_ERROR;
          bist_done_d  = 1'b1;
          bist_error_d = 1'b1;
          fail_addr_d  = bram_addr_q;
        end else if (bram_addr_q == LAST_ADDR) begin
          state_d     = S_IDLE;
          bist_done_d = 1'b1;
        end else begin
          state_d        = S_WR1;
          bram_addr_d    = bram_addr_q + ADDR_WIDTH'(1);
          bram_wr_data_d = PATT_A;
        end
      end
      S_ERROR:     state_d = S_ERROR;
`endif
      default: begin
        // All-zero state only exists between reset release and the first edge.
        state_d = S_START;
`ifdef MEMC_BIST_EN
        bram_addr_d    = '0;
        bram_wr_data_d = PATT_A;
`endif
      end
    endcase
    bram_wr_en_d = (state_d & WR_MASK) != '0;
    bram_rd_en_d = (state_d & RD_MASK) != '0;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge memc_clk or negedge memc_reset) begin
    if (!memc_reset) begin
      state_q        <= '0;
      busy_q         <= 1'b1;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      bram_rd_en_q   <= 1'b0;
      bram_wr_en_q   <= 1'b0;
      bram_addr_q    <= '0;
      bram_wr_data_q <= '0;
      bist_done_q    <= 1'b0;
      bist_error_q   <= 1'b0;
      fail_addr_q    <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      bram_rd_en_q   <= bram_rd_en_d;
      bram_wr_en_q   <= bram_wr_en_d;
      bram_addr_q    <= bram_addr_d;
      bram_wr_data_q <= bram_wr_data_d;
      bist_done_q    <= bist_done_d;
      bist_error_q   <= bist_error_d;
      fail_addr_q    <= fail_addr_d;
    end
  end

  assign memc_rd_data   = rd_data_q;
  assign memc_rd_valid  = rd_valid_q;
  assign memc_busy      = busy_q;
  assign bist_done      = bist_done_q;
  assign bist_error     = bist_error_q;
  assign bist_fail_addr = fail_addr_q;
  assign bram_rd_enable = bram_rd_en_q;
  assign bram_wr_enable = bram_wr_en_q;
  assign bram_addr      = bram_addr_q;
  assign bram_wr_data   = bram_wr_data_q;

endmodule

`default_nettype wire
